// File: rtl/shift_rows_serial_pkg.sv
// Shared AES definitions: default sizes, state geometry and the ShiftRows index map.
package shift_rows_serial_pkg;

    localparam int unsigned WORD_SIZE  = 8;
    localparam int unsigned ARRAY_SIZE = 16;
    localparam int unsigned NB_ROWS    = 4;
    localparam int unsigned NB_COLS    = 4;

    localparam int unsigned ROW_W = $clog2(NB_ROWS);
    localparam int unsigned COL_W = $clog2(NB_COLS);
    localparam int unsigned IDX_W = ROW_W + COL_W;
    localparam int unsigned NB_BANKS = 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [COL_W-1:0] col_t;

    // Column-major byte position: k = NB_ROWS*c + r.
    typedef struct packed {
        col_t col;
        row_t row;
    } pos_t;

    // Output byte k' = 4c+r is taken from stored input byte 4*((c+r) mod 4)+r.
    function automatic idx_t src_index(input idx_t k);
        pos_t dst;
        pos_t src;
        dst     = pos_t'(k);
        src.row = dst.row;
        src.col = COL_W'(dst.col + COL_W'(dst.row));
        return idx_t'(src);
    endfunction

endpackage

// File: rtl/shift_rows_bank.sv
// One 16-entry state bank: single write port, asynchronous single read port.
module shift_rows_bank
    import shift_rows_serial_pkg::*;
#(
    parameter int unsigned word_size  = WORD_SIZE,
    parameter int unsigned array_size = ARRAY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  idx_t                 wr_addr,
    input  logic [word_size-1:0] wr_data,
    input  idx_t                 rd_addr,
    output logic [word_size-1:0] rd_data
);

    logic [word_size-1:0] mem [array_size];

    // Storage: cleared on reset, one byte written per accepted input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < array_size; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read is combinational so the first byte is visible the cycle the bank fills.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows with ping-pong banks: one bank fills while the other drains.
module shift_rows_serial
    import shift_rows_serial_pkg::*;
#(
    parameter int unsigned word_size  = WORD_SIZE,
    parameter int unsigned array_size = ARRAY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [word_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam idx_t LAST_IDX = IDX_W'(array_size - 1);

    logic [NB_BANKS-1:0]  full;
    logic [NB_BANKS-1:0]  full_next;
    logic                 wr_bank;
    logic                 rd_bank;
    idx_t                 wr_cnt;
    idx_t                 rd_cnt;
    idx_t                 rd_addr;
    logic                 in_fire;
    logic                 out_fire;
    logic                 wr_wrap;
    logic                 rd_wrap;
    logic [word_size-1:0] bank_rd [NB_BANKS];

    // Handshakes are gated by reset and enable so nothing moves while either is low.
    assign in_ready  = rst & en & ~full[wr_bank];
    assign out_valid = rst & en & full[rd_bank];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign wr_wrap = (wr_cnt == LAST_IDX);
    assign rd_wrap = (rd_cnt == LAST_IDX);

    // The permutation lives entirely in the read address.
    assign rd_addr  = src_index(rd_cnt);
    assign out_last = out_valid & rd_wrap;
    assign out_data = out_valid ? bank_rd[rd_bank] : '0;

    // Two banks sharing the read address; only the write-selected bank accepts data.
    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        shift_rows_bank #(
            .word_size  (word_size),
            .array_size (array_size)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (in_fire & (wr_bank == 1'(b))),
            .wr_addr (wr_cnt),
            .wr_data (in_data),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[b])
        );
    end

    // Full flags: the filling bank and the draining bank are always distinct, so set and clear can share an edge.
    always_comb begin
        full_next = full;
        if (in_fire && wr_wrap) begin
            full_next[wr_bank] = 1'b1;
        end
        if (out_fire && rd_wrap) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // Write side: byte counter and bank pointer advance on each accepted input byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_fire) begin
            if (wr_wrap) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + idx_t'(1);
            end
        end
    end

    // Read side: byte counter and bank pointer advance on each accepted output byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (out_fire) begin
            if (rd_wrap) begin
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_cnt <= rd_cnt + idx_t'(1);
            end
        end
    end

    // Bank occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= '0;
        end else begin
            full <= full_next;
        end
    end

endmodule

// File: doc/shift_rows_serial.md
SHIFT_ROWS_SERIAL -- requirements
Module: shift_rows_serial

Interface
REQ-001 SHALL have parameter word_size, default 8, meaning bits per state byte.
REQ-002 SHALL have parameter array_size, default 16, meaning bytes per AES state block.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  global enable; when 0, no transfer occurs and all state holds.
REQ-006 SHALL have port in_data  input  word_size  input state byte.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a byte.
REQ-009 SHALL have port out_data  output  word_size  shifted state byte.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts out_data.
REQ-012 SHALL have port out_last  output  1  marks the 16th byte of an output block.

Function
REQ-013 SHALL implement forward AES ShiftRows on byte-serial blocks: s'[r][c] = s[r][(c+r) mod 4].
REQ-014 SHALL number bytes column-major, k = 4*c + r, on both input and output streams.
REQ-015 SHALL emit output byte k' = 4*c+r from stored input byte 4*((c+r) mod 4)+r.
REQ-016 SHALL transfer on input when in_valid & in_ready is high at a rising edge; likewise output on out_valid & out_ready.
REQ-017 SHALL hold two 16-byte banks (ping-pong), a write bank pointer, a read bank pointer, and a full flag per bank.
REQ-018 SHALL drive in_ready = en & ~full[wr_bank], combinationally.
REQ-019 SHALL drive out_valid = en & full[rd_bank], combinationally.
REQ-020 SHALL use a 4-bit write counter: it increments on each input transfer; on the 16th transfer it wraps to 0, sets full[wr_bank], and toggles wr_bank.
REQ-021 SHALL use a 4-bit read counter: it increments on each output transfer; on the 16th transfer it wraps to 0, clears full[rd_bank], and toggles rd_bank.
REQ-022 SHALL assert out_last when out_valid is high and the read counter equals 15.
REQ-023 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL present the first byte of a block on out_valid in the cycle after the 16th input byte is accepted (1-cycle latency from block completion).
REQ-025 SHALL sustain 1 byte/cycle in and out simultaneously when the sink never stalls.
REQ-026 SHALL allow one bank to fill and the other to drain in the same cycle, including a same-edge set of one full flag and clear of the other.
REQ-027 SHALL drive out_data = 0 whenever out_valid = 0.
REQ-028 SHALL leave counters, pointers, flags and banks unchanged while en = 0, with handshakes suppressed.

Reset
REQ-029 SHALL, on rst low, immediately clear both counters, both bank pointers, both full flags and all bank contents, independent of clk.
REQ-030 SHALL hold in_ready, out_valid, out_last and out_data at 0 while rst is low.
REQ-031 SHALL discard any partially written or partially read block when reset is applied mid-operation; the first block after reset starts at byte 0.

Structure
REQ-032 SHALL take word_size/array_size defaults, NB_ROWS=4, NB_COLS=4, and the output-to-input index mapping function from the shared AES package.
REQ-033 SHALL instantiate sub-module shift_rows_bank (16 x word_size register file, one write port, one read port) twice, or once with a bank-select address bit.

Verification
REQ-034 SHALL cover the FIPS-197 App. B round-1 vector: in d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> out d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, with out_last on e5.
REQ-035 SHALL cover back-to-back blocks with out_ready=1: three blocks in 48 consecutive cycles -> 48 consecutive output bytes, first output 1 cycle after the 16th input.
REQ-036 SHALL cover backpressure with out_ready=0: after 32 bytes are accepted, in_ready=0; raising out_ready drains block 1, and in_ready rises the cycle after its 16th byte leaves.
REQ-037 SHALL cover en=0 for 5 cycles mid-block at in byte 7 and out byte 3 -> no transfers occur and the stream resumes unaltered.
REQ-038 SHALL cover reset asserted at in byte 9 -> all outputs 0 immediately; a fresh block of bytes 00..0f afterwards yields 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
